// File: rtl/s2_control_if.sv
// s2_control_if: s1 -> s2 instruction hand-off and the decoded s2 control bundle.
//   master : fetch/s1 side (drives instruction, valid, stall_in, flush; receives controls)
//   slave  : s2_control_pipe
interface s2_control_if;
    logic        instr_valid_s1;
    logic [31:0] instruction_s1;
    logic        stall_in;
    logic        flush;
    logic [31:0] instruction_s2;
    logic        valid_s2;
    logic [1:0]  rs1_sel;
    logic [1:0]  rs2_sel;
    logic        a_sel;
    logic        b_sel;
    logic        brun;
    logic        mem_wen;
    logic        csr_we;
    logic [3:0]  alu_sel;
    logic        stall_out;

    modport master (
        output instr_valid_s1, instruction_s1, stall_in, flush,
        input  instruction_s2, valid_s2, rs1_sel, rs2_sel, a_sel, b_sel,
               brun, mem_wen, csr_we, alu_sel, stall_out
    );

    modport slave (
        input  instr_valid_s1, instruction_s1, stall_in, flush,
        output instruction_s2, valid_s2, rs1_sel, rs2_sel, a_sel, b_sel,
               brun, mem_wen, csr_we, alu_sel, stall_out
    );
endinterface

// File: rtl/s2_control_pipe.sv
// s2_control_pipe: stage-2 (decode/execute) control. Holds the s1->s2 instruction
// register, tracks rd of the last FWD_DEPTH issued instructions for forwarding,
// raises load-use / multiply stalls and decodes the gated ALU/mem/CSR controls.
// Ports: clk, rst_n (async, active-low), bus (s2_control_if.slave).
// Optional: `define S2_CTRL_MULDIV_EN adds MUL decode (alu_sel 8) and a MUL_LAT-cycle
// occupancy FSM; without it funct7[0] is ignored and no multiply stall exists.
module s2_control_pipe #(
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned MUL_LAT   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    s2_control_if.slave  bus
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_ARI_I  = 7'b0010011;
    localparam logic [6:0]  OP_ARI_R  = 7'b0110011;
    localparam logic [6:0]  OP_CSR    = 7'b1110011;

    logic [31:0]                instr_q;
    logic                       valid_q;
    logic [FWD_DEPTH-1:0]       hist_wr_q;
    logic [FWD_DEPTH-1:0]       hist_load_q;
    logic [FWD_DEPTH-1:0][4:0]  hist_rd_q;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       writes_rd, reads_rs1, reads_rs2, s2_wr;
    logic [1:0] rs1_hit, rs2_hit, rs1_sel_c, rs2_sel_c;
    logic       load_use, mul_stall, stall_c, advance;
    logic [3:0] alu_sel_c;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];

    // Register-file usage of the s2 instruction
    always_comb begin
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_ARI_I: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
            end
            OP_ARI_R: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            // CSRxxI forms carry an immediate in the rs1 field
            OP_CSR: begin
                writes_rd = 1'b1;
                reads_rs1 = ~funct3[2];
            end
            default: ;
        endcase
    end

    assign s2_wr = valid_q && writes_rd && (rd != 5'd0);

    // Youngest matching age wins: scan oldest first so younger hits overwrite
    always_comb begin
        rs1_hit = 2'd0;
        rs2_hit = 2'd0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hist_wr_q[k] && (hist_rd_q[k] == rs1)) rs1_hit = 2'(k + 1);
            if (hist_wr_q[k] && (hist_rd_q[k] == rs2)) rs2_hit = 2'(k + 1);
        end
    end

    assign rs1_sel_c = (valid_q && reads_rs1 && (rs1 != 5'd0)) ? rs1_hit : 2'd0;
    assign rs2_sel_c = (valid_q && reads_rs2 && (rs2 != 5'd0)) ? rs2_hit : 2'd0;

    // Load result is not ready at age 1; the injected bubble pushes it to age 2
    assign load_use = valid_q && hist_wr_q[0] && hist_load_q[0]
                   && ((rs1_sel_c == 2'd1) || (rs2_sel_c == 2'd1));

    assign stall_c = load_use | mul_stall;
    assign advance = !bus.stall_in && !bus.flush && !stall_c;

`ifdef S2_CTRL_MULDIV_EN
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {S_IDLE, S_BUSY} mul_state_e;

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mul_s1, mul_s2;

    assign mul_s1 = bus.instr_valid_s1 && (bus.instruction_s1[6:0] == OP_ARI_R)
                 && (bus.instruction_s1[31:25] == 7'b0000001)
                 && (bus.instruction_s1[14:12] == 3'b000);
    assign mul_s2 = (opcode == OP_ARI_R) && (instr_q[31:25] == 7'b0000001)
                 && (funct3 == 3'b000);
    assign mul_stall = (state_q == S_BUSY) && (count_q != '0);

    // Multiply occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Multiply occupancy next-state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!bus.stall_in) begin
            if (bus.flush) begin
                state_d = S_IDLE;
            end else if (advance && mul_s1 && (MUL_LAT > 1)) begin
                state_d = S_BUSY;
                count_d = CNT_W'(MUL_LAT - 1);
            end else if (state_q == S_BUSY) begin
                if (count_q != '0) count_d = count_q - CNT_W'(1);
                else               state_d = S_IDLE;
            end
        end
    end
`else
    logic unused_mul_lat;

    // MUL_LAT only matters when the multiplier is built in
    assign unused_mul_lat = ^32'(MUL_LAT);
    assign mul_stall      = 1'b0;
`endif

    // Shared funct3 -> ALU op map for register and immediate arithmetic
    always_comb begin
        alu_sel_c = 4'd0;
        if ((opcode == OP_ARI_I) || (opcode == OP_ARI_R)) begin
            unique case (funct3)
                3'b000: alu_sel_c = (opcode == OP_ARI_R && instr_q[30]) ? 4'd12 : 4'd0;
                3'b001: alu_sel_c = 4'd1;
                3'b010: alu_sel_c = 4'd2;
                3'b011: alu_sel_c = 4'd11;
                3'b100: alu_sel_c = 4'd4;
                3'b101: alu_sel_c = instr_q[30] ? 4'd13 : 4'd5;
                3'b110: alu_sel_c = 4'd6;
                3'b111: alu_sel_c = 4'd7;
                default: ;
            endcase
        end else if (opcode == OP_LUI) begin
            alu_sel_c = 4'd15;
        end
`ifdef S2_CTRL_MULDIV_EN
        if (mul_s2) alu_sel_c = 4'd8;
`endif
    end

    // s2 instruction register: stall_in > flush > local stall > advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (!bus.stall_in) begin
            if (bus.flush) begin
                instr_q <= NOP;
                valid_q <= 1'b0;
            end else if (!stall_c) begin
                instr_q <= bus.instruction_s1;
                valid_q <= bus.instr_valid_s1;
            end
        end
    end

    // Write history: current s2 retires into age 1 only when it really advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_wr_q   <= '0;
            hist_load_q <= '0;
            hist_rd_q   <= '0;
        end else if (!bus.stall_in) begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                hist_wr_q[k]   <= hist_wr_q[k-1];
                hist_load_q[k] <= hist_load_q[k-1];
                hist_rd_q[k]   <= hist_rd_q[k-1];
            end
            hist_wr_q[0]   <= advance && s2_wr;
            hist_load_q[0] <= advance && (opcode == OP_LOAD);
            hist_rd_q[0]   <= rd;
        end
    end

    assign bus.instruction_s2 = instr_q;
    assign bus.valid_s2       = valid_q;
    assign bus.rs1_sel        = rs1_sel_c;
    assign bus.rs2_sel        = rs2_sel_c;
    assign bus.a_sel          = (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_BRANCH);
    assign bus.b_sel          = !((opcode == OP_ARI_R) || (opcode == OP_BRANCH));
    assign bus.brun           = instr_q[13];
    assign bus.mem_wen        = valid_q && (opcode == OP_STORE);
    assign bus.csr_we         = valid_q && (opcode == OP_CSR) && (funct3 != 3'b000);
    assign bus.alu_sel        = alu_sel_c;
    assign bus.stall_out      = stall_c;
endmodule
